mips32_mem_arbiter: RTL and testbench
=====================================

# mips32_mem_arbiter

Single-port memory controller and run sequencer for the MIPS32 core. It shares the unified instruction/data memory between three requesters: the core's IF-stage fetch port, the core's MEM-stage data port, and an external loader/debug port. It also sequences the core through boot-load, run and post-halt readback. It sits between the core's memory ports and the synchronous RAM, and drives the core's run enable.

## Interface
- AW, default 10, memory word-address width
- DW, default 32, data width
- STARVE_LIMIT, default 4, consecutive fetch-blocked cycles before fetch is forced to win (range 1..15)

Ports:
- clk1  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- if_req / if_addr  in  1 / AW  fetch read request and address; held until granted
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid / if_rdata  out  1 / DW  fetch read-data strobe and data
- dm_req / dm_we / dm_addr / dm_wdata  in  1 / 1 / AW / DW  data-port request (dm_we=1 is a write)
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid / dm_rdata  out  1 / DW  data-port read return; none is returned for writes
- ld_req / ld_we / ld_addr / ld_wdata  in  1 / 1 / AW / DW  loader request
- ld_gnt / ld_rvalid / ld_rdata  out  1 / 1 / DW  loader grant and read return
- ld_go  in  1  one-cycle pulse that releases the core to run
- halted  in  1  core HALTED flag
- core_run  out  1  registered core run enable
- mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / AW / DW  registered RAM command
- mem_rdata  in  DW  RAM read data, valid one cycle after the command edge

## Operation
- FSM states: BOOT, RUN, DRAIN, HALT. Reset enters BOOT.
- BOOT: only the loader can be granted, and core_run=0. ld_go moves the FSM to RUN.
- RUN: core_run=1. The loader is never granted. Arbitration:
  - dm normally beats if.
  - If if_req has been blocked by a dm grant for STARVE_LIMIT consecutive cycles, the next cycle grants if even when dm_req is high.
  - The starve counter clears on an if grant, or in any cycle where if_req=0.
- RUN, halted=1: no grant is issued that cycle and the FSM moves to DRAIN. core_run drops to 0 on the same edge.
- DRAIN: no grants. Move to HALT when no read is in flight (return pipeline empty).
- HALT: same as BOOT, loader only. ld_go returns the FSM to RUN only if halted=0; otherwise ld_go is ignored.
- ld_go outside BOOT/HALT is ignored.
- Grant rule: x_gnt = x_req AND x is the winner. There is at most one grant per cycle.
- Accepted request: on the edge where x_req & x_gnt are both high, the command is registered onto mem_*:
  - mem_en=1
  - mem_we = that requester's we (fetch is always 0)
  - mem_addr and mem_wdata copied from the requester.
- Cycles with no grant register mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last value.
- Return tagging: a 2-stage tag pipe (valid + 2-bit source) follows every accepted read. The matching x_rvalid is a registered pulse. x_rdata = mem_rdata and is valid only while x_rvalid=1. Writes produce no rvalid.
- Reset mid-operation:
  - All in-flight reads are dropped; no rvalid follows.
  - FSM goes to BOOT.
  - The starve counter clears.

## Timing
- Reset values:
  - core_run=0
  - mem_en=0, mem_we=0
  - mem_addr=0, mem_wdata=0
  - all rvalid=0
  - FSM=BOOT, starve counter=0
  - all gnt=0 while no ld_req.
- Read latency: request granted in cycle N (edge E0). mem_en is high in cycle N+1, and the RAM samples at E1. x_rvalid is high in cycle N+2 (edge E1 to E2). Total: 2 cycles from grant to data.
- Throughput: one access per cycle, back-to-back, any mix of sources. Returns come back in grant order.
- Write: the RAM is updated at E1. A read of the same address granted in the next cycle returns the new data.
- Simultaneous events:
  - halted=1 and dm_req=1 in the same RUN cycle: dm is not granted.
  - ld_go and ld_req in the same BOOT cycle: ld_req is granted and the FSM still moves to RUN.
- core_run changes only on clock edges: it rises the edge after ld_go and falls on the edge that samples halted=1.

## Test plan
- Boot load: loader writes 0x2801000a to address 0, reads it back, then pulses ld_go.
  - Required: ld_rvalid 2 cycles after the read grant with ld_rdata=0x2801000a; core_run=1 on the next edge.
- Priority/starvation: in RUN with STARVE_LIMIT=4, hold if_req and dm_req high continuously.
  - Required: 4 dm grants, 1 if grant, repeating.
  - Required: if_rvalid/dm_rvalid follow the same order, each 2 cycles after its grant.
- Loader blocked: pulse ld_req in RUN.
  - Required: ld_gnt=0 throughout; if/dm traffic is unaffected.
- Halt drain: raise halted on the cycle after a dm read grant.
  - Required: no further grants; dm_rvalid still returns; FSM reaches HALT; loader read of a register-dump address is granted.
- Reset mid-flight: assert reset one cycle after an if grant.
  - Required: if_rvalid never pulses; mem_en=0, core_run=0, FSM=BOOT.
- Write-then-read: dm write 0x00000007 to address 5, then dm read of address 5 granted next cycle.
  - Required: dm_rdata=0x00000007 with dm_rvalid.

Source files
------------

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter and run sequencer for the MIPS32 core: shares one
// synchronous RAM between fetch, data and loader ports and gates the core run enable.
module mips32_mem_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    input  logic          ld_go,
    input  logic          halted,
    output logic          core_run,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    fsm_state
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] SRC_IF = 2'd0;
    localparam logic [1:0] SRC_DM = 2'd1;
    localparam logic [1:0] SRC_LD = 2'd2;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    starve_cnt;
    logic          starved;
    logic          t1_valid;
    logic [1:0]    t1_src;
    logic          acc;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [1:0]    acc_src;

    assign starved   = (starve_cnt >= 4'(STARVE_LIMIT));
    assign fsm_state = state;

    // Handshake: a request is held until its gnt is seen high; the command is
    // taken on the rising edge where req and gnt are both high.
    always_comb begin
        state_nx = state;
        if_gnt   = 1'b0;
        dm_gnt   = 1'b0;
        ld_gnt   = 1'b0;
        case (state)
            BOOT: begin
                ld_gnt = ld_req;
                if (ld_go) state_nx = RUN;
            end
            RUN: begin
                if (halted) begin
                    state_nx = DRAIN;
                end else if (if_req && (starved || !dm_req)) begin
                    if_gnt = 1'b1;
                end else begin
                    dm_gnt = dm_req;
                end
            end
            DRAIN: begin
                if (!t1_valid && !if_rvalid && !dm_rvalid && !ld_rvalid) state_nx = HALT;
            end
            HALT: begin
                ld_gnt = ld_req;
                if (ld_go && !halted) state_nx = RUN;
            end
            default: state_nx = BOOT;
        endcase
    end

    // Fetch carries no write data, so mem_wdata keeps its previous value on a fetch.
    always_comb begin
        acc       = if_gnt | dm_gnt | ld_gnt;
        acc_we    = 1'b0;
        acc_addr  = if_addr;
        acc_wdata = mem_wdata;
        acc_src   = SRC_IF;
        if (dm_gnt) begin
            acc_we    = dm_we;
            acc_addr  = dm_addr;
            acc_wdata = dm_wdata;
            acc_src   = SRC_DM;
        end else if (ld_gnt) begin
            acc_we    = ld_we;
            acc_addr  = ld_addr;
            acc_wdata = ld_wdata;
            acc_src   = SRC_LD;
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            core_run <= 1'b0;
        end else begin
            state    <= state_nx;
            core_run <= (state_nx == RUN);
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            t1_valid   <= 1'b0;
            t1_src     <= SRC_IF;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            ld_rvalid  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            mem_en   <= acc;
            mem_we   <= acc & acc_we;
            if (acc) begin
                mem_addr  <= acc_addr;
                mem_wdata <= acc_wdata;
            end
            t1_valid  <= acc & ~acc_we;
            t1_src    <= acc_src;
            if_rvalid <= t1_valid && (t1_src == SRC_IF);
            dm_rvalid <= t1_valid && (t1_src == SRC_DM);
            ld_rvalid <= t1_valid && (t1_src == SRC_LD);
            // Counts fetch cycles lost to a data grant; saturates at the limit.
            if (state != RUN || !if_req || if_gnt) begin
                starve_cnt <= '0;
            end else if (dm_gnt && !starved) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign if_rdata = mem_rdata;
    assign dm_rdata = mem_rdata;
    assign ld_rdata = mem_rdata;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: driver pushes per-cycle and read-return
// expectations, a negedge monitor pops and compares them.
module tb_mips32_mem_arbiter;

    logic        clk1 = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we, ld_req, ld_we, ld_go, halted;
    logic [9:0]  if_addr, dm_addr, ld_addr;
    logic [31:0] dm_wdata, ld_wdata;
    logic        if_gnt, dm_gnt, ld_gnt;
    logic        if_rvalid, dm_rvalid, ld_rvalid;
    logic [31:0] if_rdata, dm_rdata, ld_rdata;
    logic        core_run, mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  fsm_state;

    localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_HALT = 2'd3;
    localparam logic [2:0] G_NONE = 3'b000, G_IF = 3'b001, G_DM = 3'b010, G_LD = 3'b100;
    localparam logic [1:0] R_IF = 2'd0, R_DM = 2'd1, R_LD = 2'd2;

    // clock / reset
    always #5 clk1 = ~clk1;

    mips32_mem_arbiter #(.AW(10), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk1(clk1), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ld_go(ld_go), .halted(halted), .core_run(core_run),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fsm_state(fsm_state)
    );

    // synchronous RAM, preloaded so unwritten words read as 0xA0000000 | addr
    logic [31:0] ram [0:1023];
    initial for (int i = 0; i < 1024; i++) ram[i] = 32'hA000_0000 | 32'(i);
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // expectations: cyc_q = {gnt[2:0], core_run, state[1:0], chk_mem, mem_en}
    logic [7:0]  cyc_q[$];
    logic [33:0] exp_q[$];
    logic        done = 1'b0;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic set_in(input logic i_r, input logic [9:0] i_a,
                          input logic d_r, input logic d_w, input logic [9:0] d_a, input logic [31:0] d_d,
                          input logic l_r, input logic l_w, input logic [9:0] l_a, input logic [31:0] l_d,
                          input logic go, input logic hlt);
        if_req = i_r; if_addr = i_a;
        dm_req = d_r; dm_we = d_w; dm_addr = d_a; dm_wdata = d_d;
        ld_req = l_r; ld_we = l_w; ld_addr = l_a; ld_wdata = l_d;
        ld_go = go; halted = hlt;
    endtask

    task automatic idle_in(input logic hlt);
        set_in(0, 10'd0, 0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 0, hlt);
    endtask

    task automatic expect_cyc(input logic [2:0] g, input logic run, input logic [1:0] st,
                              input logic chk_mem, input logic me);
        cyc_q.push_back({g, run, st, chk_mem, me});
    endtask

    task automatic expect_rd(input logic [1:0] src, input logic [31:0] data);
        exp_q.push_back({src, data});
    endtask

    // driver
    initial begin
        reset = 1'b1;
        idle_in(0);
        tick();
        for (int i = 0; i < 2; i++) begin
            expect_cyc(G_NONE, 0, S_BOOT, 1, 0);
            tick();
        end
        reset = 1'b0;

        // boot load: write, read back, release
        set_in(0, 10'd0, 0, 0, 10'd0, 32'd0, 1, 1, 10'd0, 32'h2801000a, 0, 0);
        expect_cyc(G_LD, 0, S_BOOT, 1, 0);
        tick();
        set_in(0, 10'd0, 0, 0, 10'd0, 32'd0, 1, 0, 10'd0, 32'd0, 0, 0);
        expect_cyc(G_LD, 0, S_BOOT, 1, 1);
        expect_rd(R_LD, 32'h2801000a);
        tick();
        set_in(0, 10'd0, 0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 1, 0);
        expect_cyc(G_NONE, 0, S_BOOT, 1, 1);
        tick();
        idle_in(0);
        expect_cyc(G_NONE, 1, S_RUN, 1, 0);
        tick();

        // fetch and data held together: four dm grants then one if grant
        set_in(1, 10'h010, 1, 0, 10'h020, 32'd0, 0, 0, 10'd0, 32'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) begin
                expect_cyc(G_IF, 1, S_RUN, 0, 0);
                expect_rd(R_IF, 32'hA000_0010);
            end else begin
                expect_cyc(G_DM, 1, S_RUN, 0, 0);
                expect_rd(R_DM, 32'hA000_0020);
            end
            tick();
        end

        // loader request during RUN is never granted
        set_in(0, 10'd0, 1, 0, 10'h021, 32'd0, 1, 0, 10'd3, 32'd0, 0, 0);
        expect_cyc(G_DM, 1, S_RUN, 0, 0);
        expect_rd(R_DM, 32'hA000_0021);
        tick();
        set_in(1, 10'h011, 0, 0, 10'd0, 32'd0, 1, 0, 10'd3, 32'd0, 0, 0);
        expect_cyc(G_IF, 1, S_RUN, 0, 0);
        expect_rd(R_IF, 32'hA000_0011);
        tick();
        set_in(0, 10'd0, 0, 0, 10'd0, 32'd0, 1, 0, 10'd3, 32'd0, 0, 0);
        expect_cyc(G_NONE, 1, S_RUN, 0, 0);
        tick();

        // write then read of the same address
        set_in(0, 10'd0, 1, 1, 10'd5, 32'h0000_0007, 0, 0, 10'd0, 32'd0, 0, 0);
        expect_cyc(G_DM, 1, S_RUN, 0, 0);
        tick();
        set_in(0, 10'd0, 1, 0, 10'd5, 32'd0, 0, 0, 10'd0, 32'd0, 0, 0);
        expect_cyc(G_DM, 1, S_RUN, 1, 1);
        expect_rd(R_DM, 32'h0000_0007);
        tick();

        // halt drain
        set_in(0, 10'd0, 1, 0, 10'h022, 32'd0, 0, 0, 10'd0, 32'd0, 0, 0);
        expect_cyc(G_DM, 1, S_RUN, 0, 0);
        expect_rd(R_DM, 32'hA000_0022);
        tick();
        set_in(1, 10'h013, 1, 0, 10'h023, 32'd0, 0, 0, 10'd0, 32'd0, 0, 1);
        expect_cyc(G_NONE, 1, S_RUN, 0, 0);
        tick();
        idle_in(1);
        expect_cyc(G_NONE, 0, S_DRAIN, 1, 0);
        tick();
        set_in(0, 10'd0, 0, 0, 10'd0, 32'd0, 1, 0, 10'h3F0, 32'd0, 0, 1);
        expect_cyc(G_NONE, 0, S_DRAIN, 1, 0);
        tick();
        expect_cyc(G_LD, 0, S_HALT, 0, 0);
        expect_rd(R_LD, 32'hA000_03F0);
        tick();
        set_in(0, 10'd0, 0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 1, 1);
        expect_cyc(G_NONE, 0, S_HALT, 1, 1);
        tick();
        idle_in(1);
        expect_cyc(G_NONE, 0, S_HALT, 0, 0);
        tick();
        // ld_go with a loader request in the same cycle
        set_in(0, 10'd0, 0, 0, 10'd0, 32'd0, 1, 0, 10'h3F1, 32'd0, 1, 0);
        expect_cyc(G_LD, 0, S_HALT, 0, 0);
        expect_rd(R_LD, 32'hA000_03F1);
        tick();
        idle_in(0);
        expect_cyc(G_NONE, 1, S_RUN, 0, 0);
        tick();

        // reset one cycle after a fetch grant: its return must vanish
        set_in(1, 10'h012, 0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0, 0, 0);
        expect_cyc(G_IF, 1, S_RUN, 0, 0);
        tick();
        idle_in(0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expect_cyc(G_NONE, 0, S_BOOT, 1, 0);
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_cyc(G_NONE, 0, S_BOOT, 1, 0);
            tick();
        end
        done = 1'b1;
    end

    // scoreboard / monitor
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    logic [7:0]  mc;
    logic [33:0] me;
    logic [31:0] got_d;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, req);
        end
    endtask

    always @(negedge clk1) begin
        cyc_n++;
        if (cyc_q.size() > 0) begin
            mc = cyc_q.pop_front();
            cmp("gnt", {29'd0, ld_gnt, dm_gnt, if_gnt}, {29'd0, mc[7:5]});
            cmp("core_run", {31'd0, core_run}, {31'd0, mc[4]});
            cmp("state", {30'd0, fsm_state}, {30'd0, mc[3:2]});
            if (mc[1]) cmp("mem_en", {31'd0, mem_en}, {31'd0, mc[0]});
        end
        if (if_rvalid || dm_rvalid || ld_rvalid) begin
            if (exp_q.size() == 0) begin
                cmp("unexpected_rvalid", {29'd0, ld_rvalid, dm_rvalid, if_rvalid}, 32'd0);
            end else begin
                me = exp_q.pop_front();
                case (me[33:32])
                    R_IF:    got_d = if_rdata;
                    R_DM:    got_d = dm_rdata;
                    default: got_d = ld_rdata;
                endcase
                cmp("rvalid_src", {29'd0, ld_rvalid, dm_rvalid, if_rvalid}, {29'd0, 3'b001 << me[33:32]});
                cmp("rdata", got_d, me[31:0]);
            end
        end
        if (done) begin
            cmp("pending_reads", exp_q.size(), 32'd0);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

endmodule
